// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
package seg_pkg;

  localparam int unsigned NUM_COL = 9;
  localparam int unsigned NUM_ROW = 8;
  localparam int unsigned COL_W   = 4;
  localparam int unsigned ROW_W   = 3;

  localparam int unsigned SEG_BIT_A  = 0;
  localparam int unsigned SEG_BIT_B  = 1;
  localparam int unsigned SEG_BIT_C  = 2;
  localparam int unsigned SEG_BIT_D  = 3;
  localparam int unsigned SEG_BIT_E  = 4;
  localparam int unsigned SEG_BIT_F  = 5;
  localparam int unsigned SEG_BIT_G  = 6;
  localparam int unsigned SEG_BIT_DP = 7;

  typedef enum logic {BLANK, SHOW} scan_state_t;

endpackage

// File: rtl/seg_scan_timer.sv
// Column scan sequencer: BLANK/SHOW FSM with dwell counter and column index.
module seg_scan_timer #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned BLANK    = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic       show_o,
  output logic [3:0] col_o,
  output logic       frame_o
);
  import seg_pkg::*;

  localparam int unsigned CNT_MAX = (SCAN_DIV > BLANK) ? SCAN_DIV : BLANK;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  // The BLANK parameter shadows the enum literal, so states are package-qualified.
  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [COL_W-1:0] col_q, col_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= seg_pkg::BLANK;
      cnt_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    col_d   = col_q;
    unique case (state_q)
      seg_pkg::BLANK: begin
        if (cnt_q == CNT_W'(BLANK - 1)) begin
          state_d = seg_pkg::SHOW;
          cnt_d   = '0;
        end
      end
      seg_pkg::SHOW: begin
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
          state_d = seg_pkg::BLANK;
          cnt_d   = '0;
          col_d   = (col_q == COL_W'(NUM_COL - 1)) ? '0 : col_q + COL_W'(1);
        end
      end
      default: begin
        state_d = seg_pkg::BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    show_o  = (state_q == seg_pkg::SHOW);
    col_o   = col_q;
    frame_o = (state_q == seg_pkg::SHOW) && (col_q == '0) && (cnt_q == '0);
  end

endmodule

// File: rtl/seg_scan_driver.sv
// 9x8 frame buffer written by the CPU, scanned onto one-hot SEG_SEL and row buses SEG_A..SEG_H.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned BLANK    = 16
) (
  input  logic       CLK,
  input  logic       N_RST,
  input  logic       WE,
  input  logic [3:0] WCOL,
  input  logic [2:0] WROW,
  input  logic [7:0] WDATA,
  output logic [7:0] SEG_A,
  output logic [7:0] SEG_B,
  output logic [7:0] SEG_C,
  output logic [7:0] SEG_D,
  output logic [7:0] SEG_E,
  output logic [7:0] SEG_F,
  output logic [7:0] SEG_G,
  output logic [7:0] SEG_H,
  output logic [8:0] SEG_SEL,
  output logic       FRAME
);
  import seg_pkg::*;

  logic [7:0]         mem_q [NUM_COL][NUM_ROW];
  logic [7:0]         seg_q [NUM_ROW];
  logic [NUM_COL-1:0] sel_q;
  logic               frame_q;

  logic               show;
  logic [COL_W-1:0]   col;
  logic               frame;

  seg_scan_timer #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK    (BLANK)
  ) u_timer (
    .clk_i   (CLK),
    .rst_ni  (N_RST),
    .show_o  (show),
    .col_o   (col),
    .frame_o (frame)
  );

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      mem_q <= '{default: '0};
    end else if (WE && (WCOL < COL_W'(NUM_COL))) begin
      mem_q[WCOL][WROW] <= WDATA;
    end
  end

  // Rows are re-read every lit cycle from the pre-write buffer, so a write lands one cycle later.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      seg_q   <= '{default: '0};
      sel_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= frame;
      if (show) begin
        sel_q <= NUM_COL'(1) << col;
        for (int unsigned r = 0; r < NUM_ROW; r++) begin
          seg_q[r] <= mem_q[col][r];
        end
      end else begin
        sel_q <= '0;
        seg_q <= '{default: '0};
      end
    end
  end

  assign SEG_A   = seg_q[0];
  assign SEG_B   = seg_q[1];
  assign SEG_C   = seg_q[2];
  assign SEG_D   = seg_q[3];
  assign SEG_E   = seg_q[4];
  assign SEG_F   = seg_q[5];
  assign SEG_G   = seg_q[6];
  assign SEG_H   = seg_q[7];
  assign SEG_SEL = sel_q;
  assign FRAME   = frame_q;

endmodule
